// File: rtl/pe_feeder_if.sv
// Buffer, PE and control signals of the PE feeder bundled into one interface.
// The master modport is the feeder; the slave modport is the buffer/PE/controller side.
interface pe_feeder_if #(
   parameter int unsigned DATA_BITS   = 32,
   parameter int unsigned CONFIG_SIZE = 13,
   parameter int unsigned ADDR_BITS   = 10
);
   logic                   start;
   logic [CONFIG_SIZE-1:0] i_config;
   logic [ADDR_BITS-1:0]   filter_base;
   logic [ADDR_BITS-1:0]   ifmap_base;
   logic [ADDR_BITS-1:0]   ipsum_base;
   logic [ADDR_BITS-1:0]   opsum_base;
   logic                   rd_en;
   logic [ADDR_BITS-1:0]   rd_addr;
   logic [DATA_BITS-1:0]   rd_data;
   logic                   wr_en;
   logic [ADDR_BITS-1:0]   wr_addr;
   logic [DATA_BITS-1:0]   wr_data;
   logic                   PE_en;
   logic [CONFIG_SIZE-1:0] o_config;
   logic [DATA_BITS-1:0]   filter;
   logic [DATA_BITS-1:0]   ifmap;
   logic [DATA_BITS-1:0]   ipsum;
   logic                   filter_valid;
   logic                   ifmap_valid;
   logic                   ipsum_valid;
   logic                   filter_ready;
   logic                   ifmap_ready;
   logic                   ipsum_ready;
   logic [DATA_BITS-1:0]   opsum;
   logic                   opsum_valid;
   logic                   opsum_ready;
   logic                   busy;
   logic                   done;

   modport master (
      input  start, i_config, filter_base, ifmap_base, ipsum_base, opsum_base, rd_data,
             filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid,
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, PE_en, o_config, filter, ifmap, ipsum,
             filter_valid, ifmap_valid, ipsum_valid, opsum_ready, busy, done
   );

   modport slave (
      output start, i_config, filter_base, ifmap_base, ipsum_base, opsum_base, rd_data,
             filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid,
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, PE_en, o_config, filter, ifmap, ipsum,
             filter_valid, ifmap_valid, ipsum_valid, opsum_ready, busy, done
   );
endinterface

// File: rtl/pe_feeder.sv
// Sequences one PE job per start pulse: config, filter words, then per column ifmap/ipsum
// words out of the buffer and opsum words back into it.
module pe_feeder #(
   parameter int unsigned DATA_BITS   = 32,
   parameter int unsigned CONFIG_SIZE = 13,
   parameter int unsigned ADDR_BITS   = 10
) (
   input logic         clk,
   input logic         rst,
   pe_feeder_if.master bus
);

   typedef enum logic [2:0] {StIdle, StCfg, StFilter, StIfmap, StIpsum, StOpsum, StDone} state_e;
   // PhWait is the cycle in which the buffer presents rd_data for the previous request.
   typedef enum logic [1:0] {PhFetch, PhWait, PhHold} phase_e;

   state_e                 state_q, state_d, xfer_next;
   phase_e                 phase_q, phase_d;
   logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
   logic [4:0]             cnt_q, cnt_d, col_q, col_d;
   logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
   logic [DATA_BITS-1:0]   filter_q, ifmap_q, ipsum_q;

   logic [2:0]           p, q, rs, nps;
   logic [4:0]           f, n_words;
   logic                 last, chan_ready;
   logic [ADDR_BITS-1:0] col_off, xfer_addr;

   assign p       = 3'(cfg_q[8:7]) + 3'd1;
   assign q       = 3'(cfg_q[1:0]) + 3'd1;
   assign rs      = 3'(cfg_q[11:10]) + 3'd1;
   assign f       = cfg_q[6:2];
   assign nps     = cfg_q[12] ? q : p;
   assign col_off = ADDR_BITS'(col_q) * ADDR_BITS'(nps) + ADDR_BITS'(cnt_q);
   assign last    = (cnt_q == n_words - 5'd1);

   // Per-state word count, handshake source, read address and successor.
   always_comb begin
      n_words    = 5'd1;
      chan_ready = 1'b0;
      xfer_addr  = '0;
      xfer_next  = StIdle;
      case (state_q)
         StFilter: begin
            n_words    = 5'(p) * 5'(rs);
            chan_ready = bus.filter_ready;
            xfer_addr  = bus.filter_base + ADDR_BITS'(cnt_q);
            xfer_next  = StIfmap;
         end
         StIfmap: begin
            n_words    = (col_q == 5'd0) ? 5'(rs) : 5'd1;
            chan_ready = bus.ifmap_ready;
            xfer_addr  = bus.ifmap_base + ptr_q;
            xfer_next  = StIpsum;
         end
         StIpsum: begin
            n_words    = 5'(nps);
            chan_ready = bus.ipsum_ready;
            xfer_addr  = bus.ipsum_base + col_off;
            xfer_next  = StOpsum;
         end
         StOpsum: n_words = 5'(nps);
         default: ;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      phase_d         = phase_q;
      cfg_d           = cfg_q;
      cnt_d           = cnt_q;
      col_d           = col_q;
      ptr_d           = ptr_q;
      bus.rd_en       = 1'b0;
      bus.rd_addr     = '0;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.opsum_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               cfg_d   = bus.i_config;
               cnt_d   = '0;
               col_d   = '0;
               ptr_d   = '0;
               state_d = StCfg;
            end
         end
         StCfg: begin
            phase_d = PhFetch;
            state_d = StFilter;
         end
         StFilter, StIfmap, StIpsum: begin
            unique case (phase_q)
               PhFetch: begin
                  bus.rd_en   = 1'b1;
                  bus.rd_addr = xfer_addr;
                  phase_d     = PhWait;
               end
               PhWait: phase_d = PhHold;
               PhHold: begin
                  if (chan_ready) begin
                     phase_d = PhFetch;
                     if (state_q == StIfmap) ptr_d = ptr_q + ADDR_BITS'(1);
                     if (last) begin
                        cnt_d   = '0;
                        state_d = xfer_next;
                     end else begin
                        cnt_d = cnt_q + 5'd1;
                     end
                  end
               end
               default: phase_d = PhFetch;
            endcase
         end
         StOpsum: begin
            bus.opsum_ready = 1'b1;
            if (bus.opsum_valid) begin
               bus.wr_en   = 1'b1;
               bus.wr_addr = bus.opsum_base + col_off;
               bus.wr_data = bus.opsum;
               if (last) begin
                  cnt_d = '0;
                  if (col_q == f) begin
                     state_d = StDone;
                  end else begin
                     col_d   = col_q + 5'd1;
                     phase_d = PhFetch;
                     state_d = StIfmap;
                  end
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         phase_q  <= PhFetch;
         cfg_q    <= '0;
         cnt_q    <= '0;
         col_q    <= '0;
         ptr_q    <= '0;
         filter_q <= '0;
         ifmap_q  <= '0;
         ipsum_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cfg_q   <= cfg_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         ptr_q   <= ptr_d;
         if (phase_q == PhWait) begin
            if (state_q == StFilter) filter_q <= bus.rd_data;
            if (state_q == StIfmap)  ifmap_q  <= bus.rd_data;
            if (state_q == StIpsum)  ipsum_q  <= bus.rd_data;
         end
      end
   end

   assign bus.filter       = filter_q;
   assign bus.ifmap        = ifmap_q;
   assign bus.ipsum        = ipsum_q;
   assign bus.filter_valid = (state_q == StFilter) && (phase_q == PhHold);
   assign bus.ifmap_valid  = (state_q == StIfmap) && (phase_q == PhHold);
   assign bus.ipsum_valid  = (state_q == StIpsum) && (phase_q == PhHold);
   assign bus.PE_en        = (state_q == StCfg);
   assign bus.o_config     = cfg_q;
   assign bus.busy         = (state_q != StIdle);
   assign bus.done         = (state_q == StDone);

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: buffer model tags read data with its address, a PE model
// returns numbered opsums, and every channel transfer is logged and checked per job.
module tb_pe_feeder;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 13;
   localparam int unsigned AW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_feeder_if #(.DATA_BITS(DW), .CONFIG_SIZE(CW), .ADDR_BITS(AW)) bus ();

   pe_feeder #(.DATA_BITS(DW), .CONFIG_SIZE(CW), .ADDR_BITS(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Buffer: read data is the address tagged with A000_0000, garbage when not requested.
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= 32'hA000_0000 | 32'(bus.rd_addr);
      else           bus.rd_data <= 32'hDEAD_BEEF;
   end

   logic [31:0] opsum_cnt = 32'd0;
   assign bus.opsum = 32'hC0DE_0000 + opsum_cnt;

   logic [31:0] q_filter[$], q_ifmap[$], q_ipsum[$], q_wa[$], q_wd[$];
   int          n_rd = 0, n_pe = 0, n_done = 0, n_bad = 0;
   logic [12:0] cfg_seen = '0;

   always @(negedge clk) begin
      if (bus.filter_valid && bus.filter_ready) q_filter.push_back(bus.filter);
      if (bus.ifmap_valid && bus.ifmap_ready)   q_ifmap.push_back(bus.ifmap);
      if (bus.ipsum_valid && bus.ipsum_ready)   q_ipsum.push_back(bus.ipsum);
      if (bus.wr_en) begin
         q_wa.push_back(32'(bus.wr_addr));
         q_wd.push_back(bus.wr_data);
         opsum_cnt = opsum_cnt + 32'd1;
      end
      if (bus.rd_en) n_rd++;
      if (bus.done) n_done++;
      if (bus.PE_en) begin
         n_pe++;
         cfg_seen = bus.o_config;
      end
      if (int'(bus.filter_valid) + int'(bus.ifmap_valid) + int'(bus.ipsum_valid)
          + int'(bus.rd_en) + int'(bus.opsum_ready) > 1) n_bad++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string name);
      check({name, " busy"}, 32'(bus.busy), 0);
      check({name, " rd_en"}, 32'(bus.rd_en), 0);
      check({name, " wr_en"}, 32'(bus.wr_en), 0);
      check({name, " PE_en"}, 32'(bus.PE_en), 0);
      check({name, " done"}, 32'(bus.done), 0);
      check({name, " opsum_ready"}, 32'(bus.opsum_ready), 0);
      check({name, " valids"}, {29'd0, bus.filter_valid, bus.ifmap_valid, bus.ipsum_valid}, 0);
      check({name, " filter"}, bus.filter, 0);
      check({name, " ifmap"}, bus.ifmap, 0);
      check({name, " ipsum"}, bus.ipsum, 0);
      check({name, " o_config"}, 32'(bus.o_config), 0);
   endtask

   // nf = P*RS, ni = RS+F, nps = Q or P, ncol = F+1; all supplied by hand at the call site.
   task automatic run_job(input string name, input logic [12:0] cfg, input logic [9:0] fb,
                          input logic [9:0] ib, input logic [9:0] pb, input logic [9:0] ob,
                          input int nf, input int ni, input int nps, input int ncol,
                          input bit stall);
      int          f0, i0, p0, w0, rd0, pe0, dn0, bad0, cyc;
      logic [31:0] ws0, d0;
      logic [9:0]  a;
      f0 = q_filter.size(); i0 = q_ifmap.size(); p0 = q_ipsum.size(); w0 = q_wa.size();
      rd0 = n_rd; pe0 = n_pe; dn0 = n_done; bad0 = n_bad; ws0 = opsum_cnt;
      bus.i_config = cfg;
      bus.filter_base = fb; bus.ifmap_base = ib; bus.ipsum_base = pb; bus.opsum_base = ob;
      if (stall) bus.filter_ready = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check({name, " busy after start"}, 32'(bus.busy), 1);
      check({name, " PE_en"}, 32'(bus.PE_en), 1);
      if (stall) begin
         cyc = 0;
         while (!bus.filter_valid && cyc < 50) begin tick(); cyc++; end
         check({name, " stall valid seen"}, 32'(bus.filter_valid), 1);
         d0 = bus.filter;
         check({name, " stall first word"}, d0, 32'hA000_0000 | 32'(fb));
         rd0 = n_rd;
         repeat (5) begin
            tick();
            check({name, " stall valid held"}, 32'(bus.filter_valid), 1);
            check({name, " stall data stable"}, bus.filter, d0);
         end
         check({name, " stall no extra rd_en"}, 32'(n_rd), 32'(rd0));
         rd0 = rd0 - 1;
         bus.filter_ready = 1'b1;
      end
      cyc = 0;
      while (!bus.done && cyc < 3000) begin tick(); cyc++; end
      check({name, " done reached"}, 32'(bus.done), 1);
      tick();
      check({name, " idle after done"}, 32'(bus.busy), 0);
      check({name, " PE_en pulses"}, 32'(n_pe - pe0), 1);
      check({name, " o_config"}, 32'(cfg_seen), 32'(cfg));
      check({name, " done pulses"}, 32'(n_done - dn0), 1);
      check({name, " protocol"}, 32'(n_bad - bad0), 0);
      check({name, " rd_en count"}, 32'(n_rd - rd0), 32'(nf + ni + nps * ncol));
      check({name, " filter count"}, 32'(q_filter.size() - f0), 32'(nf));
      for (int i = 0; i < nf && f0 + i < q_filter.size(); i++) begin
         a = fb + 10'(i);
         check({name, " filter word"}, q_filter[f0 + i], 32'hA000_0000 | 32'(a));
      end
      check({name, " ifmap count"}, 32'(q_ifmap.size() - i0), 32'(ni));
      for (int i = 0; i < ni && i0 + i < q_ifmap.size(); i++) begin
         a = ib + 10'(i);
         check({name, " ifmap word"}, q_ifmap[i0 + i], 32'hA000_0000 | 32'(a));
      end
      check({name, " ipsum count"}, 32'(q_ipsum.size() - p0), 32'(nps * ncol));
      check({name, " write count"}, 32'(q_wa.size() - w0), 32'(nps * ncol));
      for (int i = 0; i < nps * ncol; i++) begin
         a = ob + 10'(i);
         if (w0 + i < q_wa.size()) begin
            check({name, " wr_addr"}, q_wa[w0 + i], 32'(a));
            check({name, " wr_data"}, q_wd[w0 + i], 32'hC0DE_0000 + ws0 + 32'(i));
         end
         a = pb + 10'(i);
         if (p0 + i < q_ipsum.size())
            check({name, " ipsum word"}, q_ipsum[p0 + i], 32'hA000_0000 | 32'(a));
      end
   endtask

   initial begin
      int cyc, w0;
      rst = 1'b1;
      bus.start = 1'b1;
      bus.i_config = 13'h1FFF;
      bus.filter_base = '0; bus.ifmap_base = '0; bus.ipsum_base = '0; bus.opsum_base = '0;
      bus.filter_ready = 1'b1; bus.ifmap_ready = 1'b1; bus.ipsum_ready = 1'b1;
      bus.opsum_valid = 1'b1;
      tick();
      tick();
      check_quiet("reset");
      rst = 1'b0;
      bus.start = 1'b0;
      tick();
      check("start during reset ignored", 32'(bus.busy), 0);

      run_job("minimal", 13'h000, 10'h010, 10'h040, 10'h080, 10'h100, 1, 1, 1, 1, 1'b0);
      run_job("p2q3rs3f2", 13'h88A, 10'h000, 10'h020, 10'h060, 10'h200, 6, 5, 2, 3, 1'b0);
      run_job("depthwise", 13'h1406, 10'h030, 10'h050, 10'h070, 10'h300, 2, 3, 3, 2, 1'b0);
      run_job("filter stall", 13'h000, 10'h111, 10'h222, 10'h333, 10'h044, 1, 1, 1, 1, 1'b1);

      // Abort a job while an ipsum word is held, with start asserted alongside reset.
      bus.ipsum_ready = 1'b0;
      bus.i_config = 13'h88A;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.ipsum_valid && cyc < 200) begin tick(); cyc++; end
      check("mid-ipsum reached", 32'(bus.ipsum_valid), 1);
      rst = 1'b1;
      bus.start = 1'b1;
      tick();
      check_quiet("mid-job reset");
      rst = 1'b0;
      bus.start = 1'b0;
      bus.ipsum_ready = 1'b1;
      tick();
      check("idle after mid-job reset", 32'(bus.busy), 0);
      run_job("after reset", 13'h88A, 10'h000, 10'h020, 10'h060, 10'h200, 6, 5, 2, 3, 1'b0);

      w0 = q_wa.size();
      run_job("opsum wrap", 13'h084, 10'h000, 10'h010, 10'h020, 10'd1022, 2, 2, 2, 2, 1'b0);
      if (q_wa.size() >= w0 + 4) begin
         check("wrap addr 0", q_wa[w0], 32'd1022);
         check("wrap addr 1", q_wa[w0 + 1], 32'd1023);
         check("wrap addr 2", q_wa[w0 + 2], 32'd0);
         check("wrap addr 3", q_wa[w0 + 3], 32'd1);
      end else begin
         check("wrap write count", 32'(q_wa.size() - w0), 32'd4);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
